// File: rtl/mem_arbiter.sv
// Two-port (core / loader) arbiter in front of the shared 1K x 16 program/data memory.
// Latency: grant edge -> ack edge = 2 edges; ack is a one-cycle pulse; all memory-side outputs registered.
// Backpressure: requesters hold req until ack; a port just served is masked for one cycle (RESP).
// Compile-time option: define MEM_ARB_FIXED_PRIO_EN for core-wins fixed priority (default round-robin).
module mem_arbiter #(
   parameter int AW = 10,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic          core_ack,
   output logic [DW-1:0] core_rdata,
   input  logic          ldr_req,
   input  logic          ldr_we,
   input  logic [AW-1:0] ldr_addr,
   input  logic [DW-1:0] ldr_wdata,
   output logic          ldr_ack,
   output logic [DW-1:0] ldr_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   localparam logic P_CORE = 1'b0;
   localparam logic P_LDR  = 1'b1;

   state_t        state_q, state_d;
   logic          owner_q, owner_d;
   logic          last_grant_q, last_grant_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          mem_we_q, mem_we_d;
   logic          core_ack_q, core_ack_d;
   logic          ldr_ack_q, ldr_ack_d;
   logic [DW-1:0] core_rdata_q, core_rdata_d;
   logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;

   logic          grant_vld;
   logic          grant_port;

   // Next-state: pick a winner in IDLE (or hand over directly from RESP), then sequence ACCESS -> RESP.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_we_d     = 1'b0;
      core_ack_d   = 1'b0;
      ldr_ack_d    = 1'b0;
      core_rdata_d = core_rdata_q;
      ldr_rdata_d  = ldr_rdata_q;
      grant_vld    = 1'b0;
      grant_port   = P_CORE;

      case (state_q)
         S_IDLE: begin
            if (core_req && ldr_req) begin
               grant_vld = 1'b1;
`ifdef MEM_ARB_FIXED_PRIO_EN
               grant_port = P_CORE;
`else
               // The port that did not win last time gets this one.
               grant_port = (last_grant_q == P_LDR) ? P_CORE : P_LDR;
`endif
            end else if (core_req) begin
               grant_vld  = 1'b1;
               grant_port = P_CORE;
            end else if (ldr_req) begin
               grant_vld  = 1'b1;
               grant_port = P_LDR;
            end
         end
         S_ACCESS: begin
            // mem_we_q still reflects the owner's we; a read captures the combinational memory data.
            if (!mem_we_q) begin
               if (owner_q == P_LDR) ldr_rdata_d  = mem_rdata;
               else                  core_rdata_d = mem_rdata;
            end
            if (owner_q == P_LDR) ldr_ack_d  = 1'b1;
            else                  core_ack_d = 1'b1;
            last_grant_d = owner_q;
            state_d      = S_RESP;
         end
         S_RESP: begin
            // The port just served is masked here, so only the other port can be granted.
            if (owner_q == P_CORE && ldr_req) begin
               grant_vld  = 1'b1;
               grant_port = P_LDR;
            end else if (owner_q == P_LDR && core_req) begin
               grant_vld  = 1'b1;
               grant_port = P_CORE;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (grant_vld) begin
         state_d     = S_ACCESS;
         owner_d     = grant_port;
         mem_addr_d  = (grant_port == P_LDR) ? ldr_addr  : core_addr;
         mem_wdata_d = (grant_port == P_LDR) ? ldr_wdata : core_wdata;
         mem_we_d    = (grant_port == P_LDR) ? ldr_we    : core_we;
      end
   end

   // State and registered outputs; reset wins over any in-flight access.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         owner_q      <= P_CORE;
         last_grant_q <= P_LDR;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_we_q     <= 1'b0;
         core_ack_q   <= 1'b0;
         ldr_ack_q    <= 1'b0;
         core_rdata_q <= '0;
         ldr_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_we_q     <= mem_we_d;
         core_ack_q   <= core_ack_d;
         ldr_ack_q    <= ldr_ack_d;
         core_rdata_q <= core_rdata_d;
         ldr_rdata_q  <= ldr_rdata_d;
      end
   end

   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_we     = mem_we_q;
   assign core_ack   = core_ack_q;
   assign ldr_ack    = ldr_ack_q;
   assign core_rdata = core_rdata_q;
   assign ldr_rdata  = ldr_rdata_q;
   assign busy       = (state_q == S_ACCESS) || (state_q == S_RESP);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1K x 16 memory model and a backdoor preload port.
// Inputs driven 1 time unit after posedge; outputs sampled at the same point.
// Summary line reports passed/total comparisons.
module tb_mem_arbiter;

   localparam int AW = 10;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          core_req, core_we, ldr_req, ldr_we;
   logic [AW-1:0] core_addr, ldr_addr, mem_addr;
   logic [DW-1:0] core_wdata, ldr_wdata, mem_wdata, mem_rdata;
   logic          core_ack, ldr_ack, mem_we, busy;
   logic [DW-1:0] core_rdata, ldr_rdata;

   logic          bk_we;
   logic [AW-1:0] bk_addr;
   logic [DW-1:0] bk_dat;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_ack(core_ack), .core_rdata(core_rdata),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   // Memory model: combinational read, write at the edge where mem_we is seen; reset suppresses the write.
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (bk_we) mem[bk_addr] <= bk_dat;
      else if (mem_we && !rst) mem[mem_addr] <= mem_wdata;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bk_we = 1'b1; bk_addr = a; bk_dat = d;
      tick();
      bk_we = 1'b0;
   endtask

   task automatic test_reset();
      chk_cnt++; if (mem_addr !== 10'h000) $display("FAIL reset_mem_addr got %h want 000", mem_addr); else pass_cnt++;
      chk_cnt++; if (mem_wdata !== 16'h0000) $display("FAIL reset_mem_wdata got %h want 0000", mem_wdata); else pass_cnt++;
      chk_cnt++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got %b want 0", mem_we); else pass_cnt++;
      chk_cnt++; if (core_ack !== 1'b0) $display("FAIL reset_core_ack got %b want 0", core_ack); else pass_cnt++;
      chk_cnt++; if (ldr_ack !== 1'b0) $display("FAIL reset_ldr_ack got %b want 0", ldr_ack); else pass_cnt++;
      chk_cnt++; if (core_rdata !== 16'h0000) $display("FAIL reset_core_rdata got %h want 0000", core_rdata); else pass_cnt++;
      chk_cnt++; if (ldr_rdata !== 16'h0000) $display("FAIL reset_ldr_rdata got %h want 0000", ldr_rdata); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_core_write();
      core_req = 1'b1; core_we = 1'b1; core_addr = 10'h005; core_wdata = 16'hA5A5;
      tick(); // grant edge
      chk_cnt++; if (mem_we !== 1'b1) $display("FAIL wr_mem_we_on got %b want 1", mem_we); else pass_cnt++;
      chk_cnt++; if (mem_addr !== 10'h005) $display("FAIL wr_mem_addr got %h want 005", mem_addr); else pass_cnt++;
      chk_cnt++; if (mem_wdata !== 16'hA5A5) $display("FAIL wr_mem_wdata got %h want a5a5", mem_wdata); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b1) $display("FAIL wr_busy got %b want 1", busy); else pass_cnt++;
      chk_cnt++; if (core_ack !== 1'b0) $display("FAIL wr_ack_early got %b want 0", core_ack); else pass_cnt++;
      tick(); // ack edge
      chk_cnt++; if (mem_we !== 1'b0) $display("FAIL wr_mem_we_off got %b want 0", mem_we); else pass_cnt++;
      chk_cnt++; if (core_ack !== 1'b1) $display("FAIL wr_core_ack got %b want 1", core_ack); else pass_cnt++;
      chk_cnt++; if (mem[10'h005] !== 16'hA5A5) $display("FAIL wr_mem_content got %h want a5a5", mem[10'h005]); else pass_cnt++;
      chk_cnt++; if (core_rdata !== 16'h0000) $display("FAIL wr_rdata_untouched got %h want 0000", core_rdata); else pass_cnt++;
      core_req = 1'b0;
      tick(); // RESP closes
      chk_cnt++; if (core_ack !== 1'b0) $display("FAIL wr_ack_width got %b want 0", core_ack); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL wr_back_idle got %b want 0", busy); else pass_cnt++;
      // Read the written word back.
      core_req = 1'b1; core_we = 1'b0; core_addr = 10'h005;
      tick();
      chk_cnt++; if (mem_we !== 1'b0) $display("FAIL rd_mem_we got %b want 0", mem_we); else pass_cnt++;
      tick();
      chk_cnt++; if (core_ack !== 1'b1) $display("FAIL rd_core_ack got %b want 1", core_ack); else pass_cnt++;
      chk_cnt++; if (core_rdata !== 16'hA5A5) $display("FAIL rd_core_rdata got %h want a5a5", core_rdata); else pass_cnt++;
      core_req = 1'b0;
      tick();
   endtask

   task automatic test_ldr_read();
      preload(10'h3FF, 16'h1234);
      ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 10'h3FF;
      tick();
      chk_cnt++; if (mem_addr !== 10'h3FF) $display("FAIL ldr_mem_addr got %h want 3ff", mem_addr); else pass_cnt++;
      tick();
      chk_cnt++; if (ldr_ack !== 1'b1) $display("FAIL ldr_ack got %b want 1", ldr_ack); else pass_cnt++;
      chk_cnt++; if (ldr_rdata !== 16'h1234) $display("FAIL ldr_rdata got %h want 1234", ldr_rdata); else pass_cnt++;
      chk_cnt++; if (core_rdata !== 16'hA5A5) $display("FAIL ldr_core_rdata_kept got %h want a5a5", core_rdata); else pass_cnt++;
      chk_cnt++; if (core_ack !== 1'b0) $display("FAIL ldr_no_core_ack got %b want 0", core_ack); else pass_cnt++;
      ldr_req = 1'b0;
      tick();
   endtask

   task automatic test_contention();
      // Expected per edge (bit i = edge i after requests rise): core, ldr, core, ldr with direct RESP handover.
      logic [7:0] exp_cack = 8'b0010_0010;
      logic [7:0] exp_lack = 8'b1000_1000;
      logic [7:0] exp_ldr_addr = 8'b1100_1100;
      logic [AW-1:0] want_addr;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      core_req = 1'b1; core_we = 1'b0; core_addr = 10'h005;
      ldr_req  = 1'b1; ldr_we  = 1'b0; ldr_addr  = 10'h3FF;
      for (int i = 0; i < 8; i++) begin
         tick();
         want_addr = exp_ldr_addr[i] ? 10'h3FF : 10'h005;
         chk_cnt++; if (core_ack !== exp_cack[i]) $display("FAIL cont_core_ack[%0d] got %b want %b", i, core_ack, exp_cack[i]); else pass_cnt++;
         chk_cnt++; if (ldr_ack !== exp_lack[i]) $display("FAIL cont_ldr_ack[%0d] got %b want %b", i, ldr_ack, exp_lack[i]); else pass_cnt++;
         chk_cnt++; if (mem_addr !== want_addr) $display("FAIL cont_mem_addr[%0d] got %h want %h", i, mem_addr, want_addr); else pass_cnt++;
      end
      chk_cnt++; if (core_rdata !== 16'hA5A5) $display("FAIL cont_core_rdata got %h want a5a5", core_rdata); else pass_cnt++;
      chk_cnt++; if (ldr_rdata !== 16'h1234) $display("FAIL cont_ldr_rdata got %h want 1234", ldr_rdata); else pass_cnt++;
      core_req = 1'b0; ldr_req = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_back_to_back();
      logic [6:0] exp_ack  = 7'b001_0010;
      logic [6:0] exp_busy = 7'b101_1011;
      core_req = 1'b1; core_we = 1'b0; core_addr = 10'h005;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk_cnt++; if (core_ack !== exp_ack[i]) $display("FAIL b2b_core_ack[%0d] got %b want %b", i, core_ack, exp_ack[i]); else pass_cnt++;
         chk_cnt++; if (busy !== exp_busy[i]) $display("FAIL b2b_busy[%0d] got %b want %b", i, busy, exp_busy[i]); else pass_cnt++;
      end
      core_req = 1'b0;
      tick(); // ack of last access; core is now last_grant
      tick(); // back to IDLE
   endtask

   task automatic test_rr_order();
      // Idle with the core served last: both request together at the same edge.
`ifdef MEM_ARB_FIXED_PRIO_EN
      logic exp_ldr_wins = 1'b0;
`else
      logic exp_ldr_wins = 1'b1;
`endif
      logic [AW-1:0] want_addr;
      want_addr = exp_ldr_wins ? 10'h3FF : 10'h005;
      core_req = 1'b1; ldr_req = 1'b1;
      tick();
      chk_cnt++; if (mem_addr !== want_addr) $display("FAIL rr_winner_addr got %h want %h", mem_addr, want_addr); else pass_cnt++;
      core_req = 1'b0; ldr_req = 1'b0;
      tick();
      chk_cnt++; if (ldr_ack !== exp_ldr_wins) $display("FAIL rr_ldr_ack got %b want %b", ldr_ack, exp_ldr_wins); else pass_cnt++;
      chk_cnt++; if (core_ack !== !exp_ldr_wins) $display("FAIL rr_core_ack got %b want %b", core_ack, !exp_ldr_wins); else pass_cnt++;
      tick();
      chk_cnt++; if (busy !== 1'b0) $display("FAIL rr_back_idle got %b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_reset_mid_write();
      preload(10'h010, 16'h0BAD);
      core_req = 1'b1; core_we = 1'b1; core_addr = 10'h010; core_wdata = 16'hFFFF;
      tick();
      chk_cnt++; if (mem_we !== 1'b1) $display("FAIL rmw_mem_we_on got %b want 1", mem_we); else pass_cnt++;
      rst = 1'b1;
      tick(); // would have closed ACCESS
      chk_cnt++; if (core_ack !== 1'b0) $display("FAIL rmw_no_ack got %b want 0", core_ack); else pass_cnt++;
      chk_cnt++; if (mem_we !== 1'b0) $display("FAIL rmw_mem_we got %b want 0", mem_we); else pass_cnt++;
      chk_cnt++; if (mem_addr !== 10'h000) $display("FAIL rmw_mem_addr got %h want 000", mem_addr); else pass_cnt++;
      chk_cnt++; if (mem_wdata !== 16'h0000) $display("FAIL rmw_mem_wdata got %h want 0000", mem_wdata); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL rmw_busy got %b want 0", busy); else pass_cnt++;
      chk_cnt++; if (core_rdata !== 16'h0000) $display("FAIL rmw_core_rdata got %h want 0000", core_rdata); else pass_cnt++;
      chk_cnt++; if (mem[10'h010] !== 16'h0BAD) $display("FAIL rmw_mem_content got %h want 0bad", mem[10'h010]); else pass_cnt++;
      rst = 1'b0; core_req = 1'b0;
      tick();
      chk_cnt++; if (core_ack !== 1'b0) $display("FAIL rmw_ack_after got %b want 0", core_ack); else pass_cnt++;
   endtask

   initial begin
      rst = 1'b1; bk_we = 1'b0; bk_addr = '0; bk_dat = '0;
      core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
      ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
      tick();
      tick();
      rst = 1'b0;
      test_reset();
      test_core_write();
      test_ldr_read();
      test_contention();
      test_back_to_back();
      test_rr_order();
      test_reset_mid_write();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
